bus_master: RTL

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master_pkg.sv | 26 ++
 rtl/bus_master_if.sv | 39 +++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/bus_master.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared types, widths and defaults for the bus master
package bus_master_pkg;

  localparam int ADDR_W             = 4;
  localparam int DATA_W             = 16;
  // Command word is {wr, addr, data}.
  localparam int CMD_W              = 1 + ADDR_W + DATA_W;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_TIMEOUT    = 16;
  // Wide enough for the largest TIMEOUT (255).
  localparam int TO_CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - command, response and peripheral bus signals of the bus master
// master modport: the bus_master view (i_* in, o_* out)
// slave modport : the environment view (command source, response sink, peripheral)
interface bus_master_if;
  import bus_master_pkg::*;

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_wr;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_data;

  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_err;

  logic              o_bus_select;
  logic              o_bus_wr;
  logic [ADDR_W-1:0] o_reg_addr;
  logic [DATA_W-1:0] o_bus_data;
  logic [DATA_W-1:0] i_bus_data;
  logic              i_bus_ack;

  modport master (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data,
    input  i_rsp_ready, i_bus_data, i_bus_ack,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_bus_select, o_bus_wr, o_reg_addr, o_bus_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data,
    output i_rsp_ready, i_bus_data, i_bus_ack,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_bus_select, o_bus_wr, o_reg_addr, o_bus_data
  );

endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with registered count and full/empty flags
// clk, rst          : clock, synchronous active-high reset (empties the FIFO)
// s_tvalid, s_tdata : write side; a write is taken only while not full
// m_tready, m_tdata : read side; m_tdata shows the head, m_tready pops it when not empty
// full, empty       : occupancy flags decoded from the registered count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign m_tdata = mem[rd_ptr];

  // Gating on full means a pop in the same cycle does not free a slot
  // until the following edge.
  assign push = s_tvalid & ~full;
  assign pop  = m_tready & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - queued command to single-peripheral bus master with ack timeout
// i_sysclk : system clock, rising edge
// i_sysrst : synchronous active-high reset; aborts any transaction in flight
// bus      : bus_master_if.master
//            command side  i_cmd_valid/o_cmd_ready/i_cmd_wr/i_cmd_addr/i_cmd_data
//            response side o_rsp_valid/i_rsp_ready/o_rsp_data/o_rsp_err
//            peripheral    o_bus_select/o_bus_wr/o_reg_addr/o_bus_data/i_bus_data/i_bus_ack
module bus_master
  import bus_master_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input logic          i_sysclk,
  input logic          i_sysrst,
  bus_master_if.master bus
);

  // Last REQ cycle index before the transfer is abandoned.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  state_t              state_q;
  state_t              state_d;

  cmd_t                fifo_wdata;
  cmd_t                fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  logic                bus_wr_q;
  logic [ADDR_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0]   bus_data_q;

  logic [TO_CNT_W-1:0] to_cnt_q;
  logic [TO_CNT_W-1:0] to_cnt_d;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp_err_q;
  logic                rsp_err_d;

  assign fifo_wdata = {bus.i_cmd_wr, bus.i_cmd_addr, bus.i_cmd_data};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk      (i_sysclk),
    .rst      (i_sysrst),
    .s_tvalid (bus.i_cmd_valid),
    .s_tdata  (fifo_wdata),
    .m_tready (fifo_pop),
    .m_tdata  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.o_cmd_ready  = ~fifo_full;
  assign bus.o_bus_select = (state_q == ST_REQ);
  // Qualifying with select keeps the write strobe low in RELEASE and IDLE
  // even though the command registers keep their value.
  assign bus.o_bus_wr     = bus_wr_q & (state_q == ST_REQ);
  assign bus.o_reg_addr   = reg_addr_q;
  assign bus.o_bus_data   = bus_data_q;
  assign bus.o_rsp_valid  = (state_q == ST_RESP);
  assign bus.o_rsp_data   = rsp_data_q;
  assign bus.o_rsp_err    = rsp_err_q;

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    to_cnt_d   = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (bus.i_bus_ack) begin
          rsp_data_d = bus_wr_q ? '0 : bus.i_bus_data;
          rsp_err_d  = 1'b0;
          state_d    = ST_RELEASE;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the peripheral to drop ack so a held ack cannot
        // complete the next transfer.
        if (!bus.i_bus_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      bus_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      bus_data_q <= '0;
      to_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        bus_wr_q   <= fifo_head.wr;
        reg_addr_q <= fifo_head.addr;
        bus_data_q <= fifo_head.data;
      end
      to_cnt_q   <= to_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
